// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and
// an external loader/debug port. Define DMEM_ARB_STARVE_EN to enable the
// starvation counter and forced external grant; without it the pipeline has
// strict priority and never stalls.
module dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // MEM stage requester
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  input  logic [2:0]    p_mode,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  // External requester
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  input  logic [2:0]    x_mode,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  // Data memory port
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [2:0]    m_mode,
  input  logic [DW-1:0] m_rdata
);

  localparam int unsigned CW = 4;

  // Reject starvation limits that the 4-bit counter cannot represent
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  logic x_win;

`ifdef DMEM_ARB_STARVE_EN
  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          starved;

  assign starved = (starve_cnt_q == CW'(STARVE_MAX));
  assign x_win   = x_req & (~p_req | starved);

  // Count consecutive denied external cycles; cleared on grant or idle
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (x_win || !x_req) begin
      starve_cnt_d = '0;
    end else if (p_req && !starved) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign x_win = x_req & ~p_req;
`endif

  assign x_gnt   = x_win;
  assign p_stall = p_req & x_win;
  assign p_rdata = m_rdata;

  // Steer the memory port to the winner; a losing or idle pipeline never writes
  always_comb begin
    m_we    = p_we & p_req;
    m_addr  = p_addr;
    m_wdata = p_wdata;
    m_mode  = p_mode;
    if (x_win) begin
      m_we    = x_we;
      m_addr  = x_addr;
      m_wdata = x_wdata;
      m_mode  = x_mode;
    end
  end

  logic          x_rvalid_q;
  logic          x_rvalid_d;
  logic [DW-1:0] x_rdata_q;
  logic [DW-1:0] x_rdata_d;

  // Capture read data at the grant edge of an external read
  always_comb begin
    x_rvalid_d = x_win & ~x_we;
    x_rdata_d  = x_rdata_q;
    if (x_rvalid_d) begin
      x_rdata_d = m_rdata;
    end
  end

  // External read response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_rvalid_q <= 1'b0;
      x_rdata_q  <= '0;
    end else begin
      x_rvalid_q <= x_rvalid_d;
      x_rdata_q  <= x_rdata_d;
    end
  end

  assign x_rvalid = x_rvalid_q;
  assign x_rdata  = x_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a word-addressed data memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;
  localparam int unsigned NW = 16;

  typedef struct packed {
    logic          preq;
    logic          pwe;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [2:0]    pmode;
    logic          xreq;
    logic          xwe;
    logic [AW-1:0] xaddr;
    logic [DW-1:0] xwdata;
    logic [2:0]    xmode;
  } stim_t;

  typedef struct {
    int            cyc;
    logic          gnt;
    logic          stall;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    mode;
    logic [DW-1:0] prdata;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, p_stall;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [2:0]    p_mode;
  logic          x_req, x_we, x_gnt, x_rvalid;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic [2:0]    x_mode;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [2:0]    m_mode;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_mode(p_mode), .p_rdata(p_rdata), .p_stall(p_stall),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_mode(x_mode), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge
  logic [DW-1:0] mem [NW] = '{default: '0};
  assign m_rdata = mem[m_addr[5:2]];
  always @(posedge clk) if (m_we) mem[m_addr[5:2]] <= m_wdata;

  // Reference model state
  logic [DW-1:0] ref_mem [NW] = '{default: '0};
  int   waited = 0;
  int   cyc = 0;
  bit   rst_chk = 1'b0;
  exp_t expq[$];
  rd_t  rdq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations and compares DUT outputs at the falling edge
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    bit   exp_rv;
    if (!rst) begin
      rdq.delete();
      expq.delete();
      if (rst_chk) begin
        chk("reset_x_rvalid", 64'(x_rvalid), 64'(0));
        chk("reset_x_rdata", 64'(x_rdata), 64'(0));
      end
    end else begin
      exp_rv = (rdq.size() != 0) && (rdq[0].cyc == cyc - 1);
      chk("x_rvalid", 64'(x_rvalid), 64'(exp_rv));
      if (exp_rv) begin
        r = rdq.pop_front();
        if (x_rvalid) chk("x_rdata", 64'(x_rdata), 64'(r.data));
      end
      if (expq.size() != 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("x_gnt", 64'(x_gnt), 64'(e.gnt));
        chk("p_stall", 64'(p_stall), 64'(e.stall));
        chk("m_we", 64'(m_we), 64'(e.we));
        chk("m_addr", 64'(m_addr), 64'(e.addr));
        chk("m_mode", 64'(m_mode), 64'(e.mode));
        if (e.we) chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
        chk("p_rdata", 64'(p_rdata), 64'(e.prdata));
      end
    end
  end

  // Drive one cycle of stimulus and record what the arbitration rules predict
  task automatic step(input stim_t s, output bit xw);
    exp_t e;
    rd_t  r;
    p_req = s.preq;  p_we = s.pwe;  p_addr = s.paddr;
    p_wdata = s.pwdata;  p_mode = s.pmode;
    x_req = s.xreq;  x_we = s.xwe;  x_addr = s.xaddr;
    x_wdata = s.xwdata;  x_mode = s.xmode;
    cyc++;
    if (!s.xreq) xw = 1'b0;
    else if (!s.preq) xw = 1'b1;
    else begin
`ifdef DMEM_ARB_STARVE_EN
      xw = (waited == int'(SM));
`else
      xw = 1'b0;
`endif
    end
    waited = (xw || !s.xreq) ? 0 : waited + 1;
    e.cyc    = cyc;
    e.gnt    = xw;
    e.stall  = s.preq & xw;
    e.we     = xw ? s.xwe : (s.preq & s.pwe);
    e.addr   = xw ? s.xaddr : s.paddr;
    e.wdata  = xw ? s.xwdata : s.pwdata;
    e.mode   = xw ? s.xmode : s.pmode;
    e.prdata = ref_mem[e.addr[5:2]];
    expq.push_back(e);
    if (xw && !s.xwe) begin
      r.cyc  = cyc;
      r.data = ref_mem[s.xaddr[5:2]];
      rdq.push_back(r);
    end
    if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input bit preq, input bit pwe, input int pa,
                               input logic [DW-1:0] pd, input bit xreq,
                               input bit xwe, input int xa, input logic [DW-1:0] xd);
    stim_t s;
    s.preq = preq;  s.pwe = pwe;  s.paddr = AW'(pa);  s.pwdata = pd;  s.pmode = 3'd2;
    s.xreq = xreq;  s.xwe = xwe;  s.xaddr = AW'(xa);  s.xwdata = xd;  s.xmode = 3'd2;
    return s;
  endfunction

  task automatic do_reset();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_mode = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_mode = '0;
    rst = 1'b0;
    rst_chk = 1'b1;
    waited = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rst_chk = 1'b0;
  endtask

  initial begin
    stim_t s;
    bit    xw;
    bit    got;
    bit    last_stall;
    // Power-on reset
    rst = 1'b0;
    rst_chk = 1'b1;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_mode = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset: no write, no stall
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);
    // External write then read of 0x10 with pipeline idle
    step(mk(0, 0, 0, '0, 1, 1, 'h10, 32'hDEADBEEF), xw);
    step(mk(0, 0, 0, '0, 1, 0, 'h10, '0), xw);
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);

    // Contention: continuous pipeline loads vs external write 0x20
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step(mk(1, 0, 'h0, '0, 1, 1, 'h20, 32'hCAFE0001), xw);
      got = xw;
    end
    if (!got) step(mk(0, 0, 'h0, '0, 1, 1, 'h20, 32'hCAFE0001), xw);
    step(mk(0, 0, 0, '0, 1, 0, 'h20, '0), xw);
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);

    // Pipeline store 0x55 to 0x24 competing with an external write
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(mk(1, 1, 'h24, 32'h55, !got, 1, 'h3C, 32'h77), xw);
      got = got | xw;
    end
    step(mk(0, 0, 0, '0, 1, 0, 'h24, '0), xw);
    step(mk(0, 0, 0, '0, 1, 0, 'h3C, '0), xw);
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);

    // Pipeline load pass-through
    step(mk(1, 1, 'h30, 32'h12345678, 0, 0, 0, '0), xw);
    step(mk(1, 0, 'h30, '0, 0, 0, 0, '0), xw);

    // Reset while a read response is pending
    step(mk(0, 0, 0, '0, 1, 0, 'h10, '0), xw);
    step(mk(0, 0, 0, '0, 1, 0, 'h10, '0), xw);
    do_reset();
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);

    // Randomized traffic honouring the hold rules
    s = mk(0, 0, 0, '0, 0, 0, 0, '0);
    xw = 1'b0;
    last_stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(s.preq && last_stall)) begin
        s.preq   = ($urandom_range(0, 9) < 7);
        s.pwe    = 1'($urandom_range(0, 1));
        s.paddr  = AW'($urandom_range(0, NW - 1) * 4);
        s.pwdata = DW'($urandom());
        s.pmode  = 3'($urandom_range(0, 7));
      end
      if (!(s.xreq && !xw)) begin
        s.xreq   = ($urandom_range(0, 9) < 5);
        s.xwe    = 1'($urandom_range(0, 1));
        s.xaddr  = AW'($urandom_range(0, NW - 1) * 4);
        s.xwdata = DW'($urandom());
        s.xmode  = 3'($urandom_range(0, 7));
      end
      step(s, xw);
      last_stall = s.preq & xw;
    end

    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);
    step(mk(0, 0, 0, '0, 0, 0, 0, '0), xw);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage and an external loader/debug port. The block sits between the MEM pipeline register outputs and data_memory. It grants the port to one requester per cycle. When the pipeline loses arbitration it raises a stall to the hazard unit, and external reads complete with a registered, valid-qualified response.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive denied cycles after which the external port is forced a grant (legal range 1–15)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `p_req`  in  1  MEM stage needs memory (load or store in M); driven from the M pipeline register
- `p_we`  in  1  MEM stage store
- `p_addr`  in  AW  MEM stage address (ALUResultM)
- `p_wdata`  in  DW  store data (WriteDataM)
- `p_mode`  in  3  access size/sign (mem_modeM encoding)
- `p_rdata`  out  DW  load data, combinational pass-through of `m_rdata`
- `p_stall`  out  1  MEM stage denied this cycle; hazard unit freezes F/D/E/M and bubbles W
- `x_req`  in  1  external request; held until granted
- `x_we`  in  1  external write
- `x_addr`  in  AW  external address
- `x_wdata`  in  DW  external write data
- `x_mode`  in  3  external access size
- `x_gnt`  out  1  external request accepted this cycle
- `x_rvalid`  out  1  external read data valid (registered)
- `x_rdata`  out  DW  external read data (registered)
- `m_we`  out  1  to data_memory MemWriteM
- `m_addr`  out  AW  to data_memory
- `m_wdata`  out  DW  to data_memory
- `m_mode`  out  3  to data_memory
- `m_rdata`  in  DW  from data_memory ReadData (combinational read)

## Operation
**Grant decision** is combinational from inputs and registered `starve_cnt`:
- `x_win = x_req & (~p_req | starve_cnt == STARVE_MAX)`
- `x_gnt = x_win`
- `p_stall = p_req & x_win`
- P-wins otherwise; with no requests, the port idles.

**Memory mux:**
- When `x_win`: `m_* = x_*`.
- Else: `m_addr`, `m_wdata`, `m_mode` = `p_*`, and `m_we = p_we & p_req`.
- When neither requester wins, `m_we = 0`.

**starve_cnt** (4-bit, saturating at `STARVE_MAX`):
- Cleared on `x_win` or when `x_req == 0`.
- Incremented when `x_req & p_req & ~x_win`.

**Read response:**
- On a granted external read (`x_win & ~x_we`), `x_rdata <= m_rdata` and `x_rvalid <= 1` at that edge.
- `x_rvalid` is otherwise 0 and is a single-cycle pulse.
- External writes complete at the grant edge and produce no `x_rvalid`.

**Handshake:** `x_*` must stay stable while `x_req=1 & x_gnt=0`. `x_req` may drop the cycle after `x_gnt` or issue a new request back-to-back.

**Write hazard:** a pipeline store denied by `p_stall` is not written that cycle. It is re-presented unchanged next cycle because M is frozen.

## Timing
- Reset (`rst=0`, asynchronous): `starve_cnt=0`, `x_rvalid=0`, `x_rdata=0`. Combinational outputs follow inputs.
- An external read or write in flight at reset is dropped; the requester re-issues it.
- `p_rdata` latency: 0 cycles.
- `x_rdata`/`x_rvalid` latency: 1 cycle after the grant edge.
- Back-to-back external reads: one per cycle when the pipeline is idle.
- Worst-case external wait under continuous `p_req`: `STARVE_MAX` denied cycles, granted on cycle `STARVE_MAX+1`.
- Worst-case pipeline stall per forced grant: 1 cycle. The counter clears on the grant, so the next forced grant is at least `STARVE_MAX+1` cycles away.
- Simultaneous `p_req` and `x_req` with `starve_cnt < STARVE_MAX`: the pipeline wins and `starve_cnt` increments.
- `p_stall` depends only on the M register, `x_*` and `starve_cnt`. There is no combinational loop through the hazard unit.

## Configuration
- **`DMEM_ARB_STARVE_EN` defined:** starvation counter and forced grant operate as above.
- **Not defined:**
  - `starve_cnt` is removed and the arbiter is strict pipeline-priority: `x_win = x_req & ~p_req`.
  - `p_stall` is constant 0.
  - External requests can wait indefinitely.

## Test plan
- **Reset:** assert `rst=0` mid-run with `x_rvalid=1` → `x_rvalid=0`, `x_rdata=0` immediately. After release with no requests, `m_we=0`, `p_stall=0`.
- **External read, pipeline idle:** `x_req=1`, `x_we=0`, `x_addr=0x10`, memory word `0xDEADBEEF` → `x_gnt=1` same cycle; next cycle `x_rvalid=1`, `x_rdata=0xDEADBEEF`; following cycle `x_rvalid=0`.
- **Contention, `STARVE_MAX=4`:** `p_req=1` continuous, `x_req=1` write `0xCAFE0001` to `0x20` → `x_gnt` low 4 cycles, high on the 5th with `p_stall=1` that cycle only. Memory `0x20 = 0xCAFE0001`; `starve_cnt` returns to 0.
- **Stalled pipeline store:** the pipeline store `0x55` to `0x24` is denied by the forced grant → no write that cycle. Written next cycle; readback returns `0x55` and the store is never duplicated.
- **Pipeline load pass-through:** `p_req=1` load from `0x30` holding `0x12345678`, no `x_req` → `p_rdata=0x12345678` same cycle, `p_stall=0`.
- **Macro off, continuous `p_req`:** `x_req` is never granted over 50 cycles and `p_stall` stays 0. Dropping `p_req` grants `x_req` that cycle.
